// File: rtl/sha256_pkg.sv
// Shared constants, state encoding and byte-lane helpers for the SHA-256 padder.
// Blocks are big-endian: byte 0 sits in bits [511:504], byte 63 in bits [7:0].
package sha256_pkg;

    localparam int BLOCK_W      = 512;
    localparam int LEN_W        = 64;
    localparam int NBYTES       = BLOCK_W / 8;
    localparam int LEN_BYTE_POS = 56;
    localparam logic [7:0] PAD_MARKER = 8'h80;

    typedef enum logic [1:0] {
        S_LOAD,
        S_PAD,
        S_EMIT,
        S_TAIL
    } state_t;

    // Overwrite byte lane idx (0 = most significant) of a block.
    function automatic logic [BLOCK_W-1:0] put_byte(
        input logic [BLOCK_W-1:0] blk,
        input int                 idx,
        input logic [7:0]         val
    );
        logic [BLOCK_W-1:0] r;
        r = blk;
        r[8*(NBYTES-1-idx) +: 8] = val;
        return r;
    endfunction

    // Byte k (0 = most significant) of the big-endian length field.
    function automatic logic [7:0] len_byte(
        input logic [LEN_W-1:0] len,
        input int               k
    );
        return len[8*(7-k) +: 8];
    endfunction

endpackage

// File: rtl/sha256_padder.sv
// Byte-serial SHA-256 message padder producing 512-bit blocks with first/final tags.
// Ports: clk, reset (async high); in_data/in_valid/in_last/in_ready byte input;
//        block_out/block_valid/block_ready/block_first/block_final block output.
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int CNT_W = 61
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    output logic [BLOCK_W-1:0] block_out,
    output logic               block_valid,
    input  logic               block_ready,
    output logic               block_first,
    output logic               block_final
);

    state_t             state_q, state_d;
    logic [BLOCK_W-1:0] buf_q, buf_d;
    logic [6:0]         ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               first_q, first_d;
    logic               final_q, final_d;
    logic               tail_pending_q, tail_pending_d;
    logic               tail_marker_q, tail_marker_d;
    logic               in_ready_q, in_ready_d;
    logic               block_valid_q, block_valid_d;

    logic [LEN_W-1:0]   len_w;
    logic               pad_fits;

    // Bit length of the message, modulo 2^LEN_W.
    assign len_w    = LEN_W'(cnt_q) << 3;
    // Marker and length both fit in the current block.
    assign pad_fits = ptr_q < 7'(LEN_BYTE_POS);

    always_comb begin
        state_d        = state_q;
        buf_d          = buf_q;
        ptr_d          = ptr_q;
        cnt_d          = cnt_q;
        first_d        = first_q;
        final_d        = final_q;
        tail_pending_d = tail_pending_q;
        tail_marker_d  = tail_marker_q;

        unique case (state_q)
            S_LOAD: begin
                if (in_valid && in_ready_q) begin
                    buf_d = put_byte(buf_q, int'(ptr_q[5:0]), in_data);
                    ptr_d = ptr_q + 7'd1;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (in_last) begin
                        state_d = S_PAD;
                    end else if (ptr_q == 7'd63) begin
                        final_d = 1'b0;
                        state_d = S_EMIT;
                    end
                end
            end
            S_PAD: begin
                // ptr_q == 64 matches no lane: the full block goes out as-is.
                for (int i = 0; i < NBYTES; i++) begin
                    if (7'(i) == ptr_q) begin
                        buf_d = put_byte(buf_d, i, PAD_MARKER);
                    end else if (7'(i) > ptr_q) begin
                        if (pad_fits && i >= LEN_BYTE_POS) begin
                            buf_d = put_byte(buf_d, i,
                                len_byte(len_w, i - LEN_BYTE_POS));
                        end else begin
                            buf_d = put_byte(buf_d, i, 8'h00);
                        end
                    end
                end
                final_d        = pad_fits;
                tail_pending_d = !pad_fits;
                tail_marker_d  = ptr_q == 7'd64;
                state_d        = S_EMIT;
            end
            S_EMIT: begin
                if (block_valid_q && block_ready) begin
                    first_d = 1'b0;
                    if (final_q) begin
                        buf_d   = '0;
                        cnt_d   = '0;
                        ptr_d   = '0;
                        first_d = 1'b1;
                        state_d = S_LOAD;
                    end else if (tail_pending_q) begin
                        state_d = S_TAIL;
                    end else begin
                        buf_d   = '0;
                        ptr_d   = '0;
                        state_d = S_LOAD;
                    end
                end
            end
            S_TAIL: begin
                buf_d = '0;
                if (tail_marker_q) begin
                    buf_d = put_byte(buf_d, 0, PAD_MARKER);
                end
                for (int k = 0; k < 8; k++) begin
                    buf_d = put_byte(buf_d, LEN_BYTE_POS + k,
                        len_byte(len_w, k));
                end
                ptr_d          = '0;
                tail_pending_d = 1'b0;
                tail_marker_d  = 1'b0;
                final_d        = 1'b1;
                state_d        = S_EMIT;
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase

        // Handshake flags are registered from the next state.
        in_ready_d    = state_d == S_LOAD;
        block_valid_d = state_d == S_EMIT;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_LOAD;
            buf_q          <= '0;
            ptr_q          <= '0;
            cnt_q          <= '0;
            first_q        <= 1'b1;
            final_q        <= 1'b0;
            tail_pending_q <= 1'b0;
            tail_marker_q  <= 1'b0;
            in_ready_q     <= 1'b0;
            block_valid_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            buf_q          <= buf_d;
            ptr_q          <= ptr_d;
            cnt_q          <= cnt_d;
            first_q        <= first_d;
            final_q        <= final_d;
            tail_pending_q <= tail_pending_d;
            tail_marker_q  <= tail_marker_d;
            in_ready_q     <= in_ready_d;
            block_valid_q  <= block_valid_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign block_out   = buf_q;
    assign block_valid = block_valid_q;
    assign block_first = block_valid_q & first_q;
    assign block_final = block_valid_q & final_q;

endmodule

// File: tb/tb_sha256_padder.sv
// Randomized bench for sha256_padder against a FIPS 180-4 padding model.
// Drives on the falling edge, samples on the falling edge.
module tb_sha256_padder;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [511:0] block_out;
    logic         block_valid;
    logic         block_ready;
    logic         block_first;
    logic         block_final;

    always #5 clk = ~clk;

    sha256_padder #(.CNT_W(61)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .block_out   (block_out),
        .block_valid (block_valid),
        .block_ready (block_ready),
        .block_first (block_first),
        .block_final (block_final)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [511:0] got,
                         input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Stimulus and reference state
    logic [7:0]   msg_q[$];
    logic [7:0]   exp_bytes[$];
    int           nblk;
    int           rdy_mode = 0;
    int           stall_n  = 0;
    bit           last_sent = 0;
    int           last_edge = 0;

    // Monitor state
    logic [511:0] rx_blk[$];
    bit           rx_first[$];
    bit           rx_final[$];
    int           rise_cyc = 0;
    bit           prev_valid = 0;
    bit           prev_stall = 0;
    bit           xfer_prev  = 0;
    bit           exp_rdy_after = 0;
    logic [511:0] prev_out;
    logic         prev_first, prev_final;

    initial begin
        block_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_valid  = 0;
                prev_stall  = 0;
                xfer_prev   = 0;
                block_ready = 1'b0;
                continue;
            end
            case (rdy_mode)
                0: block_ready = 1'b1;
                1: block_ready = ($urandom_range(0, 2) != 0);
                default: begin
                    if (block_valid && stall_n < 10) begin
                        block_ready = 1'b0;
                        stall_n++;
                    end else begin
                        block_ready = 1'b1;
                    end
                end
            endcase
            if (xfer_prev)
                check("in_ready_after_xfer", 512'(in_ready),
                      512'(exp_rdy_after));
            if (prev_stall) begin
                check("stall_valid", 512'(block_valid), 512'(1));
                check("stall_data", block_out, prev_out);
                check("stall_first", 512'(block_first), 512'(prev_first));
                check("stall_final", 512'(block_final), 512'(prev_final));
            end
            if (block_valid)
                check("in_ready_while_valid", 512'(in_ready), 512'(0));
            if (block_valid && !prev_valid) rise_cyc = cyc;
            xfer_prev = block_valid && block_ready;
            if (xfer_prev) begin
                rx_blk.push_back(block_out);
                rx_first.push_back(block_first);
                rx_final.push_back(block_final);
                exp_rdy_after = block_final || !last_sent;
                stall_n = 0;
            end
            prev_stall = block_valid && !block_ready;
            prev_out   = block_out;
            prev_first = block_first;
            prev_final = block_final;
            prev_valid = block_valid;
        end
    end

    // FIPS 180-4 padding: msg || 0x80 || 0* || 64-bit big-endian bit length
    task automatic build_exp(input int n);
        logic [63:0] bitlen;
        exp_bytes.delete();
        for (int i = 0; i < n; i++) exp_bytes.push_back(msg_q[i]);
        exp_bytes.push_back(8'h80);
        while (exp_bytes.size() % 64 != 56) exp_bytes.push_back(8'h00);
        bitlen = 64'(n) * 64'd8;
        for (int k = 7; k >= 0; k--) exp_bytes.push_back(bitlen[8*k +: 8]);
        nblk = exp_bytes.size() / 64;
    endtask

    task automatic send_bytes(input int n, input bit with_last);
        int w;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_data  = msg_q[i];
            in_last  = with_last && (i == n - 1);
            in_valid = 1'b1;
            w = 0;
            while (!in_ready && w < 300) begin
                @(negedge clk);
                w++;
            end
            if (w >= 300) begin
                check("in_ready_timeout", 512'(0), 512'(1));
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
            if (in_last) begin
                last_sent = 1;
                last_edge = cyc + 1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic fill(input int n, input bit rnd);
        msg_q.delete();
        for (int i = 0; i < n; i++)
            msg_q.push_back(rnd ? 8'($urandom) : 8'h61);
    endtask

    task automatic run_msg(input int mode, input bit chk_lat);
        int w;
        logic [511:0] e;
        rdy_mode  = mode;
        stall_n   = 0;
        last_sent = 0;
        rx_blk.delete();
        rx_first.delete();
        rx_final.delete();
        build_exp(msg_q.size());
        send_bytes(msg_q.size(), 1);
        w = 0;
        while (rx_blk.size() < nblk && w < 2000) begin
            @(negedge clk);
            w++;
        end
        check("blocks_rx", 512'(rx_blk.size()), 512'(nblk));
        for (int b = 0; b < nblk && b < rx_blk.size(); b++) begin
            e = '0;
            for (int j = 0; j < 64; j++) e = {e[503:0], exp_bytes[64*b + j]};
            check($sformatf("blk%0d_data", b), rx_blk[b], e);
            check($sformatf("blk%0d_first", b), 512'(rx_first[b]),
                  512'(b == 0));
            check($sformatf("blk%0d_final", b), 512'(rx_final[b]),
                  512'(b == nblk - 1));
        end
        if (chk_lat)
            check("latency", 512'(rise_cyc), 512'(last_edge + 1));
        repeat (5) @(negedge clk);
        check("no_extra_blocks", 512'(rx_blk.size()), 512'(nblk));
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_block_out"}, block_out, 512'(0));
        check({pfx, "_in_ready"}, 512'(in_ready), 512'(0));
        check({pfx, "_valid"}, 512'(block_valid), 512'(0));
        check({pfx, "_first"}, 512'(block_first), 512'(0));
        check({pfx, "_final"}, 512'(block_final), 512'(0));
    endtask

    initial begin
        reset    = 1'b1;
        in_data  = 8'h00;
        in_valid = 1'b0;
        in_last  = 1'b0;
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("in_ready_pre_edge", 512'(in_ready), 512'(0));
        @(negedge clk);
        check("in_ready_post_edge", 512'(in_ready), 512'(1));

        // "hello"
        msg_q = '{8'h68, 8'h65, 8'h6c, 8'h6c, 8'h6f};
        run_msg(0, 1);
        check("hello_const", rx_blk[0],
              {8'h68, 8'h65, 8'h6c, 8'h6c, 8'h6f, 8'h80, 400'b0, 64'h28});

        // Padding boundaries
        fill(55, 0);
        run_msg(1, 0);
        check("len55_field", 512'(rx_blk[0][63:0]), 512'(64'h1B8));
        fill(56, 0);
        run_msg(1, 0);
        check("len56_tail", rx_blk[1], 512'(64'h1C0));
        fill(64, 0);
        run_msg(1, 0);
        check("len64_tail", rx_blk[1], {8'h80, 440'b0, 64'h200});

        // Sustained backpressure, including a tail block
        fill(20, 1);
        run_msg(2, 0);
        fill(60, 1);
        run_msg(2, 0);

        // Random lengths and data
        for (int t = 0; t < 8; t++) begin
            fill(t < 3 ? $urandom_range(54, 65) : $urandom_range(1, 150), 1);
            run_msg(1, 0);
        end

        // Reset in the middle of a message
        rdy_mode = 0;
        fill(30, 1);
        send_bytes(30, 0);
        #2;
        reset = 1'b1;
        #1;
        check_outputs_zero("midreset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        msg_q = '{8'h61, 8'h62, 8'h63};
        run_msg(0, 1);
        check("abc_const", rx_blk[0],
              {8'h61, 8'h62, 8'h63, 8'h80, 416'b0, 64'h18});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
